bitwise_unit: RTL and testbench

- Combinational bitwise logic block: per-bit inverse, AND, OR, XOR of two operand vectors, plus XNOR.
- Also provides a clocked saturating count of cycles on which the operands differ.
- Small utility block in the datapath, and the simplest logic sanity check for the emulation flow.
- With WIDTH=1 it matches the legacy scalar bitwise interface.

---
 rtl/bitwise_unit_if.sv | 38 +++
 rtl/bitwise_unit.sv | 113 +++++++++++
 tb/tb_bitwise_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bitwise_unit_if.sv
// Bundles the operand and result signals of bitwise_unit.
//   master: drives a/b and observes the results (testbench or upstream logic)
//   slave : the bitwise_unit side; consumes a/b and drives every result
// Signals:
//   a, b      [WIDTH]  operands
//   a_inv     [WIDTH]  ~a
//   b_inv     [WIDTH]  ~b
//   a_and_b   [WIDTH]  a & b
//   a_or_b    [WIDTH]  a | b
//   a_xor_b   [WIDTH]  a ^ b
//   a_xnor_b  [WIDTH]  ~(a ^ b)
//   diff_cnt  [CNT_W]  saturating count of cycles with a != b
//   diff_sat  [1]      diff_cnt is at its maximum value
interface bitwise_unit_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_inv;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] a_and_b;
  logic [WIDTH-1:0] a_or_b;
  logic [WIDTH-1:0] a_xor_b;
  logic [WIDTH-1:0] a_xnor_b;
  logic [CNT_W-1:0] diff_cnt;
  logic             diff_sat;

  modport master (
    output a, b,
    input  a_inv, b_inv, a_and_b, a_or_b, a_xor_b, a_xnor_b, diff_cnt, diff_sat
  );

  modport slave (
    input  a, b,
    output a_inv, b_inv, a_and_b, a_or_b, a_xor_b, a_xnor_b, diff_cnt, diff_sat
  );
endinterface

// File: rtl/bitwise_unit.sv
// Per-bit logic block (inverse, AND, OR, XOR, XNOR of two operands) plus a
// saturating count of clock cycles on which the operands differ.
// Ports:
//   clk  rising-edge clock for the counter (and output registers if enabled)
//   rst  asynchronous reset, active-low
//   bus  bitwise_unit_if.slave: operands in, logic results and counter out
// Configuration:
//   BITWISE_OUT_REG_EN  when defined, the six logic results are registered
//                       (one-cycle latency, async reset to 0); otherwise they
//                       are purely combinational and independent of clk/rst.
// The interface instance must be built with the same WIDTH/CNT_W as this module.
module bitwise_unit #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  bitwise_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Combinational results; each bit depends only on a[i]/b[i].
  logic [WIDTH-1:0] a_inv_c;
  logic [WIDTH-1:0] b_inv_c;
  logic [WIDTH-1:0] a_and_b_c;
  logic [WIDTH-1:0] a_or_b_c;
  logic [WIDTH-1:0] a_xor_b_c;
  logic [WIDTH-1:0] a_xnor_b_c;

  always_comb begin
    a_inv_c    = ~bus.a;
    b_inv_c    = ~bus.b;
    a_and_b_c  = bus.a & bus.b;
    a_or_b_c   = bus.a | bus.b;
    a_xor_b_c  = bus.a ^ bus.b;
    a_xnor_b_c = ~(bus.a ^ bus.b);
  end

`ifdef BITWISE_OUT_REG_EN
  logic [WIDTH-1:0] a_inv_q;
  logic [WIDTH-1:0] b_inv_q;
  logic [WIDTH-1:0] a_and_b_q;
  logic [WIDTH-1:0] a_or_b_q;
  logic [WIDTH-1:0] a_xor_b_q;
  logic [WIDTH-1:0] a_xnor_b_q;

  // All registers clear to 0, including the inverted outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_inv_q    <= '0;
      b_inv_q    <= '0;
      a_and_b_q  <= '0;
      a_or_b_q   <= '0;
      a_xor_b_q  <= '0;
      a_xnor_b_q <= '0;
    end else begin
      a_inv_q    <= a_inv_c;
      b_inv_q    <= b_inv_c;
      a_and_b_q  <= a_and_b_c;
      a_or_b_q   <= a_or_b_c;
      a_xor_b_q  <= a_xor_b_c;
      a_xnor_b_q <= a_xnor_b_c;
    end
  end

  always_comb begin
    bus.a_inv    = a_inv_q;
    bus.b_inv    = b_inv_q;
    bus.a_and_b  = a_and_b_q;
    bus.a_or_b   = a_or_b_q;
    bus.a_xor_b  = a_xor_b_q;
    bus.a_xnor_b = a_xnor_b_q;
  end
`else
  always_comb begin
    bus.a_inv    = a_inv_c;
    bus.b_inv    = b_inv_c;
    bus.a_and_b  = a_and_b_c;
    bus.a_or_b   = a_or_b_c;
    bus.a_xor_b  = a_xor_b_c;
    bus.a_xnor_b = a_xnor_b_c;
  end
`endif

  // Difference counter: increments while operands differ, sticks at all-ones.
  logic [CNT_W-1:0] diff_cnt_q;
  logic [CNT_W-1:0] diff_cnt_d;
  logic             diff_sat_c;

  always_comb begin
    diff_sat_c = (diff_cnt_q == CntMax);
    diff_cnt_d = diff_cnt_q;
    if ((bus.a != bus.b) && !diff_sat_c) begin
      diff_cnt_d = diff_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff_cnt_q <= '0;
    end else begin
      diff_cnt_q <= diff_cnt_d;
    end
  end

  always_comb begin
    bus.diff_cnt = diff_cnt_q;
    bus.diff_sat = diff_sat_c;
  end

endmodule

// File: tb/tb_bitwise_unit.sv
// Testbench for bitwise_unit (default build, combinational logic outputs).
// Three instances: WIDTH=1/CNT_W=8, WIDTH=8/CNT_W=8, WIDTH=1/CNT_W=2.
// Stimulus pushes hand-computed expectations into a scoreboard queue and
// raises chk_ev; a monitor process pops and compares against the DUTs.
module tb_bitwise_unit;

  logic clk;
  logic rst;

  bitwise_unit_if #(.WIDTH(1), .CNT_W(8)) if_w1 ();
  bitwise_unit_if #(.WIDTH(8), .CNT_W(8)) if_w8 ();
  bitwise_unit_if #(.WIDTH(1), .CNT_W(2)) if_c2 ();

  bitwise_unit #(.WIDTH(1), .CNT_W(8)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1));
  bitwise_unit #(.WIDTH(8), .CNT_W(8)) u_w8 (.clk(clk), .rst(rst), .bus(if_w8));
  bitwise_unit #(.WIDTH(1), .CNT_W(2)) u_c2 (.clk(clk), .rst(rst), .bus(if_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation ids
  localparam int unsigned ObsW1Logic = 0;  // {a_inv,b_inv,and,or,xor,xnor}, 1 bit each
  localparam int unsigned ObsW8Logic = 1;  // same order, 8 bits each
  localparam int unsigned ObsW1Cnt   = 2;  // {diff_sat, diff_cnt[7:0]}
  localparam int unsigned ObsC2Cnt   = 3;  // {diff_sat, diff_cnt[1:0]}

  typedef struct {
    int unsigned id;
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  event        chk_ev;
  int unsigned n_checks;
  int unsigned n_fail;
  exp_t        mon_e;
  logic [63:0] mon_act;

  function automatic logic [63:0] get_obs(input int unsigned id);
    case (id)
      ObsW1Logic: return {58'b0, if_w1.a_inv, if_w1.b_inv, if_w1.a_and_b, if_w1.a_or_b,
                          if_w1.a_xor_b, if_w1.a_xnor_b};
      ObsW8Logic: return {16'b0, if_w8.a_inv, if_w8.b_inv, if_w8.a_and_b, if_w8.a_or_b,
                          if_w8.a_xor_b, if_w8.a_xnor_b};
      ObsW1Cnt:   return {55'b0, if_w1.diff_sat, if_w1.diff_cnt};
      ObsC2Cnt:   return {61'b0, if_c2.diff_sat, if_c2.diff_cnt};
      default:    return 64'hx;
    endcase
  endfunction

  task automatic expect_obs(input int unsigned id, input string name, input logic [63:0] exp);
    exp_t e;
    e.id   = id;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation when stimulus says outputs are stable.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        mon_e   = sb_q.pop_front();
        mon_act = get_obs(mon_e.id);
        n_checks++;
        if (mon_act !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  // Directed WIDTH=1 truth table: {a, b, expected 6-bit result}
  logic [7:0] w1_tab [4];
  // Directed WIDTH=8 vectors: {a, b, expected 48-bit result}
  logic [63:0] w8_tab [3];

  initial begin
    w1_tab[0] = {2'b00, 6'b110001};
    w1_tab[1] = {2'b01, 6'b100110};
    w1_tab[2] = {2'b10, 6'b010110};
    w1_tab[3] = {2'b11, 6'b001101};
    w8_tab[0] = {8'hA5, 8'h0F, 8'h5A, 8'hF0, 8'h05, 8'hAF, 8'hAA, 8'h55};
    w8_tab[1] = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
    w8_tab[2] = {8'h3C, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 8'h3C, 8'h00, 8'hFF};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int unsigned c2v;
  int unsigned w1v;

  initial begin
    rst     = 1'b0;
    if_w1.a = 1'b0;
    if_w1.b = 1'b0;
    if_w8.a = 8'h00;
    if_w8.b = 8'h00;
    if_c2.a = 1'b0;
    if_c2.b = 1'b0;
    #2;

    // Reset state of counters
    #1;
    expect_obs(ObsW1Cnt, "reset_w1_cnt", 64'h0);
    expect_obs(ObsC2Cnt, "reset_c2_cnt", 64'h0);
    ->chk_ev;
    #1;

    // Logic outputs while held in reset (combinational path ignores rst)
    for (int i = 0; i < 4; i++) begin
      if_w1.a = w1_tab[i][7];
      if_w1.b = w1_tab[i][6];
      #1;
      expect_obs(ObsW1Logic, $sformatf("w1_logic_%0d", i), {58'b0, w1_tab[i][5:0]});
      ->chk_ev;
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      if_w8.a = w8_tab[i][63:56];
      if_w8.b = w8_tab[i][55:48];
      #1;
      expect_obs(ObsW8Logic, $sformatf("w8_logic_%0d", i), {16'b0, w8_tab[i][47:0]});
      ->chk_ev;
      #1;
    end

    // Counting: release reset between edges with operands already differing.
    @(negedge clk);
    if_w1.a = 1'b1;
    if_w1.b = 1'b0;
    if_c2.a = 1'b1;
    if_c2.b = 1'b0;
    rst     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      w1v = (k <= 5) ? k : 5;
      c2v = (k <= 3) ? k : 3;
      expect_obs(ObsW1Cnt, $sformatf("w1_cnt_edge%0d", k), {55'b0, 1'b0, 8'(w1v)});
      expect_obs(ObsC2Cnt, $sformatf("c2_cnt_edge%0d", k), {61'b0, (c2v == 3), 2'(c2v)});
      ->chk_ev;
      @(negedge clk);
      if (k + 1 > 5) begin
        if_w1.a = 1'b1;
        if_w1.b = 1'b1;
      end
      if (k + 1 > 6) begin
        if_c2.a = 1'b0;
        if_c2.b = 1'b0;
      end
    end

    // Mid-count reset clears immediately, no clock edge needed.
    #2;
    rst = 1'b0;
    #1;
    expect_obs(ObsC2Cnt, "c2_async_clear", 64'h0);
    expect_obs(ObsW1Cnt, "w1_async_clear", 64'h0);
    ->chk_ev;

    // First edge after release counts.
    @(negedge clk);
    if_c2.a = 1'b0;
    if_c2.b = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    expect_obs(ObsC2Cnt, "c2_first_edge", 64'h1);
    expect_obs(ObsW1Cnt, "w1_equal_hold", 64'h0);
    ->chk_ev;
    #2;

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
